// File: rtl/dd_scan_driver_pkg.sv
// Shared types and constants for the dual 4-digit 7-segment scan driver.
// Also holds the LED source selector values written by the IO register block.
package dd_scan_driver_pkg;

  localparam int COUNT_WIDTH = 28;
  localparam int CYCLE_WIDTH = 32;

  typedef logic [COUNT_WIDTH-1:0] CountPath;
  typedef logic [CYCLE_WIDTH-1:0] CyclePath;
  typedef logic [15:0]            DD_OutArray;
  typedef logic [7:0]             DD_GateArray;
  typedef logic [31:0]            LED_InArray;
  typedef logic [1:0]             DigitIdx;

  localparam CountPath DEF_COUNT = 28'h3000;

  localparam logic LED_CTRL_SORT_RESULT = 1'b0;
  localparam logic LED_CTRL_USER        = 1'b1;

  localparam int SEG7_DP_BIT = 7;
  typedef logic [6:0] Seg7Path;

  function automatic logic [3:0] digitOneHot(input DigitIdx k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/dd_scan_driver_if.sv
// Bundle of source inputs and display outputs between the IO register block
// and the scan driver.
interface dd_scan_driver_if;
  import dd_scan_driver_pkg::*;

  logic        ledCtrl;
  CyclePath    cycleCount;
  CyclePath    sortCount;
  logic        sortFinish;
  LED_InArray  userLed;
  DD_OutArray  ddOut;
  DD_GateArray ddGate;

  modport master (
    output ledCtrl, cycleCount, sortCount, sortFinish, userLed,
    input  ddOut, ddGate
  );

  modport slave (
    input  ledCtrl, cycleCount, sortCount, sortFinish, userLed,
    output ddOut, ddGate
  );

endinterface

// File: rtl/dd_scan_driver_hex.sv
// Combinational hex digit to 7-segment decoder, segment order {g,f,e,d,c,b,a},
// active-high.
module hex_to_seg7
  import dd_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output Seg7Path    seg
);

  always_comb begin
    seg = '0;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/dd_scan_driver.sv
// Time-multiplexed scan driver for two 4-digit 7-segment displays: snapshots the
// selected source once per frame and drives registered segments and digit gates.
module dd_scan_driver
  import dd_scan_driver_pkg::*;
#(
  parameter CountPath SCAN_PERIOD  = DEF_COUNT,
  parameter int       BLANK_CYCLES = 16
)
(
  input logic             clk,
  input logic             rst,
  dd_scan_driver_if.slave bus
);

  CountPath    p;
  DigitIdx     k;
  logic [15:0] v0, v1;
  logic        dpBuf;
  logic        loadPending;

  logic        pWrap, frameEdge, blank;
  logic [3:0]  nib0, nib1;
  Seg7Path     seg0, seg1;
  logic [15:0] loadV0, loadV1;
  logic        loadDp;
  DD_OutArray  outNext;
  DD_GateArray gateNext;
  logic        unusedHighBits;

  assign unusedHighBits = ^{bus.cycleCount[CYCLE_WIDTH-1:16], bus.sortCount[CYCLE_WIDTH-1:16]};

  always_comb begin
    pWrap     = (p == SCAN_PERIOD - CountPath'(1));
    frameEdge = pWrap && (k == 2'd3);
    blank     = (p < CountPath'(BLANK_CYCLES));
    // Digit 0 is the most significant nibble, so index with (3-k) == ~k.
    nib0      = v0[{~k, 2'b00} +: 4];
    nib1      = v1[{~k, 2'b00} +: 4];
  end

  // User nibble 0 lands in the most significant digit of each display.
  always_comb begin
    loadV0 = bus.cycleCount[15:0];
    loadV1 = bus.sortCount[15:0];
    loadDp = bus.sortFinish;
    if (bus.ledCtrl == LED_CTRL_USER) begin
      loadV0 = {bus.userLed[3:0],   bus.userLed[7:4],   bus.userLed[11:8],  bus.userLed[15:12]};
      loadV1 = {bus.userLed[19:16], bus.userLed[23:20], bus.userLed[27:24], bus.userLed[31:28]};
      loadDp = 1'b0;
    end
  end

  hex_to_seg7 uHex0 (.nibble(nib0), .seg(seg0));
  hex_to_seg7 uHex1 (.nibble(nib1), .seg(seg1));

  always_comb begin
    gateNext = '0;
    outNext  = '0;
    if (!blank) begin
      gateNext                   = {digitOneHot(k), digitOneHot(k)};
      outNext[6:0]               = seg0;
      outNext[14:8]              = seg1;
      outNext[8 + SEG7_DP_BIT]   = dpBuf && (k == 2'd3);
    end
  end

  // Prescaler, digit counter, frame snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p           <= '0;
      k           <= '0;
      v0          <= '0;
      v1          <= '0;
      dpBuf       <= 1'b0;
      loadPending <= 1'b1;
      bus.ddOut   <= '0;
      bus.ddGate  <= '0;
    end else begin
      p <= pWrap ? '0 : p + CountPath'(1);
      if (pWrap) begin
        k <= k + 2'd1;
      end
      if (loadPending || frameEdge) begin
        v0    <= loadV0;
        v1    <= loadV1;
        dpBuf <= loadDp;
      end
      loadPending <= 1'b0;
      bus.ddOut   <= outNext;
      bus.ddGate  <= gateNext;
    end
  end

endmodule

// File: tb/tb_dd_scan_driver.sv
// Self-checking bench for dd_scan_driver with SCAN_PERIOD=8, BLANK_CYCLES=2:
// table-driven source vectors plus mid-frame change, mid-frame reset and ledCtrl toggling.
module tb_dd_scan_driver;
  import dd_scan_driver_pkg::*;

  typedef struct {
    string       name;
    logic        ledCtrl;
    logic [31:0] userLed;
    logic [31:0] cycleCount;
    logic [31:0] sortCount;
    logic        sortFinish;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } VecT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  VecT  vecs[5];

  dd_scan_driver_if bus();

  dd_scan_driver #(.SCAN_PERIOD(28'd8), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  task automatic setSources(input VecT v);
    bus.ledCtrl    = v.ledCtrl;
    bus.userLed    = v.userLed;
    bus.cycleCount = v.cycleCount;
    bus.sortCount  = v.sortCount;
    bus.sortFinish = v.sortFinish;
  endtask

  // Holds reset for two sampled cycles with the vector's sources applied, then releases on a negedge.
  task automatic applyStimulus(input VecT v);
    @(negedge clk);
    rst = 1'b1;
    setSources(v);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compare({v.name, " rstGate"}, 32'(bus.ddGate), 32'h0);
      compare({v.name, " rstOut"}, 32'(bus.ddOut), 32'h0);
    end
    rst = 1'b0;
  endtask

  // Sample c follows release edge c+1, whose outputs come from p=c%8, k=(c/8)%4.
  task automatic checkOutput(input logic [31:0] e0, input logic [31:0] e1,
                             input int cStart, input int cEnd, input string tag);
    for (int c = cStart; c < cEnd; c++) begin
      int          pp;
      int          kk;
      logic [3:0]  oh;
      logic [7:0]  gExp;
      logic [15:0] oExp;
      @(negedge clk);
      pp   = c % 8;
      kk   = (c / 8) % 4;
      oh   = 4'b0001 << kk;
      gExp = 8'h00;
      oExp = 16'h0000;
      if (pp >= 2) begin
        gExp = {oh, oh};
        oExp = {e1[(3-kk)*8 +: 8], e0[(3-kk)*8 +: 8]};
      end
      compare($sformatf("%s gate c=%0d", tag, c), 32'(bus.ddGate), 32'(gExp));
      compare($sformatf("%s out c=%0d", tag, c), 32'(bus.ddOut), 32'(oExp));
    end
  endtask

  initial begin
    vecs[0] = '{"zeros", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0,
                32'h3F3F_3F3F, 32'h3F3F_3F3F};
    vecs[1] = '{"userHi", 1'b1, 32'hFEDC_BA98, 32'h0000_1234, 32'h0000_00A5, 1'b1,
                32'h7F6F_777C, 32'h395E_7971};
    vecs[2] = '{"sortRes", 1'b0, 32'hFEDC_BA98, 32'h0000_1234, 32'h0000_00A5, 1'b1,
                32'h065B_4F66, 32'h3F3F_77ED};
    vecs[3] = '{"userLo", 1'b1, 32'h7654_3210, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                32'h3F06_5B4F, 32'h666D_7D07};
    vecs[4] = '{"sortHex", 1'b0, 32'h1111_1111, 32'hFFFF_89AB, 32'h1234_CDEF, 1'b0,
                32'h7F6F_777C, 32'h395E_7971};

    setSources(vecs[0]);

    // Past one frame boundary so the second 8'h11 slot is also covered.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].exp0, vecs[i].exp1, 0, 40, vecs[i].name);
    end

    // userLed changes at k=1; old digits stay until the frame boundary.
    applyStimulus(vecs[1]);
    checkOutput(vecs[1].exp0, vecs[1].exp1, 0, 10, "midChgA");
    bus.userLed = 32'h7654_3210;
    checkOutput(vecs[1].exp0, vecs[1].exp1, 10, 32, "midChgB");
    checkOutput(vecs[3].exp0, vecs[3].exp1, 32, 64, "midChgC");

    // Reset while p=5, k=2 must clear outputs before the next clock edge.
    applyStimulus(vecs[1]);
    checkOutput(vecs[1].exp0, vecs[1].exp1, 0, 21, "preRst");
    #1;
    rst = 1'b1;
    setSources(vecs[2]);
    #1;
    compare("asyncRstGate", 32'(bus.ddGate), 32'h0);
    compare("asyncRstOut", 32'(bus.ddOut), 32'h0);
    applyStimulus(vecs[2]);
    checkOutput(vecs[2].exp0, vecs[2].exp1, 0, 40, "postRst");

    // ledCtrl toggles every 3 cycles: 0 at load edges 1 and 32, 1 at edge 64.
    applyStimulus(vecs[2]);
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          repeat (3) @(negedge clk);
          bus.ledCtrl = ~bus.ledCtrl;
        end
      end
      begin
        checkOutput(vecs[2].exp0, vecs[2].exp1, 0, 64, "toggleSort");
        checkOutput(vecs[1].exp0, vecs[1].exp1, 64, 96, "toggleUser");
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dd_scan_driver.md
# dd_scan_driver

Time-multiplexed scan driver for the two 4-digit 7-segment displays on the board. It sits directly downstream of the IO register block. It takes either the sort-result counters or the eight user-written LED nibbles, selected by the LED control register. It snapshots the selected source once per frame, hex-decodes it and drives registered segment and digit-gate outputs with an anti-ghosting blank interval.

## Interface
- SCAN_PERIOD, 28'h3000 (DEF_COUNT): clock cycles per digit slot; legal range 2 .. 2^COUNT_WIDTH-1.
- BLANK_CYCLES, 16: cycles at the start of each slot with all gates off; must be < SCAN_PERIOD.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset asynchronous, active-high.
- ledCtrl  in  1  LED_CTRL_SORT_RESULT (0) or LED_CTRL_USER (1).
- cycleCount  in  CYCLE_WIDTH  current cycle count.
- sortCount  in  CYCLE_WIDTH  sort count.
- sortFinish  in  1  sort-finished flag.
- userLed  in  LED_InArray (32)  user nibbles; nibble i at [i*4 +: 4], i = 0..7.
- ddOut  out  DD_OutArray (16)  segments; display d at [d*8 +: 8], bit order {dp,g,f,e,d,c,b,a}, active-high.
- ddGate  out  DD_GateArray (8)  digit enables; display d at [d*4 +: 4], one-hot or zero, active-high.

## Operation
- Prescaler p (CountPath): counts 0..SCAN_PERIOD-1 and wraps to 0. Digit index k (2 bits) increments on p wrap; wrap 3->0 is the frame boundary.
- Both displays scan the same k simultaneously. Gate bit k selects digit k, and digit 0 is leftmost (most significant).
- Frame buffer (two 16-bit values plus one dp bit) loads at every frame boundary and on the first clock after rst deasserts (loadPending flag set by reset).
  - ledCtrl=0: V0 = cycleCount[15:0], V1 = sortCount[15:0], dp = sortFinish.
  - ledCtrl=1: V0 = {userLed nibbles 0,1,2,3} with nibble 0 as the MS digit; V1 = nibbles 4..7 likewise; dp = 0.
- Changes to ledCtrl or to any source between loads are invisible until the next load.
- Digit k of display d shows hex decode of Vd[(3-k)*4 +: 4]. Display 1 digit 3 dp bit = dp; every other dp = 0.
- Hex decode, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Blank phase (p < BLANK_CYCLES): ddGate = 0 and ddOut = 0. Otherwise ddGate[d] = onehot(k) and ddOut[d] = decoded digit.

## Timing
- Reset values: p=0, k=0, frame buffer=0, loadPending=1, ddOut=0, ddGate=0.
- ddOut/ddGate are flops computed from (p, k, buffer) of the previous cycle, so latency is one cycle.
- The gate first lights on the edge after p = BLANK_CYCLES is present, i.e. BLANK_CYCLES+1 edges after reset release.
- Digit slot length is exactly SCAN_PERIOD cycles; frame length is 4*SCAN_PERIOD cycles.
- The buffer loads on the same edge at which k wraps 3->0, so the new frame's first lit digit uses the new data.
- Reset mid-frame: all state and outputs clear asynchronously. Scanning restarts at k=0 with a fresh load after release.
- No output glitch between slots: the gate drops to 0 for BLANK_CYCLES before the next digit lights.

## Structure
- Shared package already provides CountPath, DD_*Array, LED_InArray, CyclePath, DEF_COUNT and the LED_CTRL_* constants.
- Add a SEG7_DP_BIT = 7 constant and a Seg7Path typedef to the package.
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit decoder, instantiated twice (once per display).
- Top level holds the prescaler, digit counter, frame buffer and output registers.

## Test plan
All scenarios use SCAN_PERIOD=8, BLANK_CYCLES=2.
- Reset, then hold: ddGate=0 and ddOut=0 during reset and for 2 edges after release. Then ddGate=8'h11 for 6 cycles, 0 for 2, 8'h22 for 6, and so on through 8'h88, then back to 8'h11.
- ledCtrl=1, userLed=32'hFEDC_BA98, i.e. nibble0=8 ... nibble7=F:
  - display 0 digits 0..3 = 7F,6F,77,7C;
  - display 1 digits 0..3 = 39,5E,79,71;
  - all dp=0.
- ledCtrl=0, cycleCount=32'h0000_1234, sortCount=32'h0000_00A5, sortFinish=1: display 0 = 06,5B,4F,66; display 1 = 3F,3F,77,ED (ED = 6D with dp set).
- Change userLed mid-frame at k=1: the displayed digits stay unchanged until the k 3->0 wrap, then show the new value on the first lit slot.
- Assert rst while k=2, p=5: outputs go to 0 before the next clk edge. After release the sequence matches scenario 1 with a fresh snapshot.
- Toggle ledCtrl every 3 cycles: the display source changes only at frame boundaries; no mixed-source frame is ever shown.
